// File: rtl/xinput_reader.sv
// Memory-mapped input peripheral: synchronised slide switches, a debounced push-button
// with a sticky press flag and an 8-bit press counter, read over the data bus.
module xinput_reader #(
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              we,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  input  logic [7:0]        Sw,
  input  logic              Btn3,
  output logic              btn_irq
);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_PEND,
    PRESSED,
    RELEASE_PEND
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [7:0]       sw_meta_q, sw_sync_q;
  logic             btn_meta_q, btn_sync_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_flag_q, press_flag_d;
  logic [7:0]       press_cnt_q, press_cnt_d;
  logic             accept;
  logic             btn_level;
  logic             rd_flag, wr_flag, wr_cnt;

  // Write data carries no information: writes are pure clear strobes.
  logic unused_data_in;
  assign unused_data_in = ^data_in;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_meta_q    <= '0;
      sw_sync_q    <= '0;
      btn_meta_q   <= 1'b0;
      btn_sync_q   <= 1'b0;
      state_q      <= RELEASED;
      cnt_q        <= '0;
      press_flag_q <= 1'b0;
      press_cnt_q  <= '0;
    end else begin
      sw_meta_q    <= Sw;
      sw_sync_q    <= sw_meta_q;
      btn_meta_q   <= Btn3;
      btn_sync_q   <= btn_meta_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      press_flag_q <= press_flag_d;
      press_cnt_q  <= press_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      RELEASED: begin
        if (btn_sync_q) begin
          state_d = PRESS_PEND;
          cnt_d   = CNT_ONE;
        end
      end
      PRESS_PEND: begin
        if (!btn_sync_q) begin
          state_d = RELEASED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          accept  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!btn_sync_q) begin
          state_d = RELEASE_PEND;
          cnt_d   = CNT_ONE;
        end
      end
      RELEASE_PEND: begin
        if (btn_sync_q) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RELEASED;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  assign btn_irq   = accept;
  assign btn_level = (state_q == PRESSED) || (state_q == RELEASE_PEND);

  always_comb begin
    rd_flag = sel && !we && (addr == 2'd1);
    wr_flag = sel &&  we && (addr == 2'd1);
    wr_cnt  = sel &&  we && (addr == 2'd2);

    // Clears are applied first so a coinciding accept wins / counts from zero.
    press_flag_d = press_flag_q;
    if (rd_flag || wr_flag) press_flag_d = 1'b0;
    if (accept)             press_flag_d = 1'b1;

    press_cnt_d = wr_cnt ? 8'd0 : press_cnt_q;
    if (accept) press_cnt_d = press_cnt_d + 8'd1;
  end

  always_comb begin
    data_out = '0;
    if (sel) begin
      unique case (addr)
        2'd0:    data_out[7:0] = sw_sync_q;
        2'd1:    data_out[1:0] = {btn_level, press_flag_q};
        2'd2:    data_out[7:0] = press_cnt_q;
        default: data_out      = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_xinput_reader.sv
// Directed bench for xinput_reader with a short debounce window (4 cycles).
module tb_xinput_reader;

  logic        clk;
  logic        rst;
  logic        sel;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic [7:0]  Sw;
  logic        Btn3;
  logic        btn_irq;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  xinput_reader #(
    .DATA_W(32),
    .DEBOUNCE_CYCLES(4),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sel(sel),
    .we(we),
    .addr(addr),
    .data_in(data_in),
    .data_out(data_out),
    .Sw(Sw),
    .Btn3(Btn3),
    .btn_irq(btn_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus helpers: called just after a falling edge, return just after the next one.
  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    sel = 1'b1; we = 1'b0; addr = a;
    #1 d = data_out;
    @(negedge clk);
    sel = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] a);
    sel = 1'b1; we = 1'b1; addr = a; data_in = 32'hDEAD_BEEF;
    @(negedge clk);
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic press_once(output int unsigned irqs);
    irqs = 0;
    Btn3 = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (btn_irq) irqs++;
    end
    Btn3 = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (btn_irq) irqs++;
    end
  endtask

  task automatic test_reset;
    #1;
    n_checks++;
    if (data_out !== 32'h0) begin
      n_fail++; $display("FAIL reset_unsel: got %h want %h", data_out, 32'h0);
    end
    n_checks++;
    if (btn_irq !== 1'b0) begin
      n_fail++; $display("FAIL reset_irq: got %b want 0", btn_irq);
    end
    for (int unsigned a = 0; a < 3; a++) begin
      sel = 1'b1; addr = a[1:0];
      #1;
      n_checks++;
      if (data_out !== 32'h0) begin
        n_fail++; $display("FAIL reset_read%0d: got %h want %h", a, data_out, 32'h0);
      end
    end
    sel = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_sw_sync;
    Sw = 8'hA5; sel = 1'b1; we = 1'b0; addr = 2'd0;
    #1;
    n_checks++;
    if (data_out !== 32'h0) begin
      n_fail++; $display("FAIL sw_lag0: got %h want %h", data_out, 32'h0);
    end
    @(negedge clk);
    n_checks++;
    if (data_out !== 32'h0) begin
      n_fail++; $display("FAIL sw_lag1: got %h want %h", data_out, 32'h0);
    end
    @(negedge clk);
    n_checks++;
    if (data_out !== 32'h0000_00A5) begin
      n_fail++; $display("FAIL sw_lag2: got %h want %h", data_out, 32'h0000_00A5);
    end
    addr = 2'd3;
    #1;
    n_checks++;
    if (data_out !== 32'h0) begin
      n_fail++; $display("FAIL addr3_zero: got %h want %h", data_out, 32'h0);
    end
    sel = 1'b0; addr = 2'd0;
    #1;
    n_checks++;
    if (data_out !== 32'h0) begin
      n_fail++; $display("FAIL unsel_zero: got %h want %h", data_out, 32'h0);
    end
    @(negedge clk);
  endtask

  task automatic test_bounce;
    int unsigned irqs;
    logic [31:0] d;
    irqs = 0;
    Btn3 = 1'b1;
    for (int unsigned k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 2) Btn3 = 1'b0;
      if (btn_irq) irqs++;
    end
    n_checks++;
    if (irqs !== 0) begin
      n_fail++; $display("FAIL bounce_irq: got %0d want 0", irqs);
    end
    bus_read(2'd1, d);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++; $display("FAIL bounce_flag: got %h want %h", d, 32'h0);
    end
    bus_read(2'd2, d);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++; $display("FAIL bounce_cnt: got %h want %h", d, 32'h0);
    end
  endtask

  task automatic test_press;
    int unsigned irqs;
    logic [31:0] d;
    irqs = 0;
    Btn3 = 1'b1;
    for (int unsigned k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (btn_irq) irqs++;
      n_checks++;
      if (btn_irq !== (k == 5)) begin
        n_fail++; $display("FAIL press_irq_k%0d: got %b want %b", k, btn_irq, (k == 5));
      end
    end
    n_checks++;
    if (irqs !== 1) begin
      n_fail++; $display("FAIL press_irq_count: got %0d want 1", irqs);
    end
    bus_read(2'd1, d);
    n_checks++;
    if (d !== 32'h3) begin
      n_fail++; $display("FAIL press_read1a: got %h want %h", d, 32'h3);
    end
    bus_read(2'd1, d);
    n_checks++;
    if (d !== 32'h2) begin
      n_fail++; $display("FAIL press_read1b: got %h want %h", d, 32'h2);
    end
    Btn3 = 1'b0;
    repeat (8) @(negedge clk);
    bus_read(2'd1, d);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++; $display("FAIL release_level: got %h want %h", d, 32'h0);
    end
  endtask

  task automatic test_wrap;
    int unsigned irqs;
    int unsigned total;
    logic [31:0] d;
    total = 0;
    bus_write(2'd2);
    bus_read(2'd2, d);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++; $display("FAIL wrap_clear: got %h want %h", d, 32'h0);
    end
    for (int unsigned i = 0; i < 255; i++) begin
      press_once(irqs);
      total += irqs;
    end
    bus_read(2'd2, d);
    n_checks++;
    if (d !== 32'h0000_00FF) begin
      n_fail++; $display("FAIL wrap_255: got %h want %h", d, 32'hFF);
    end
    press_once(irqs);
    total += irqs;
    bus_read(2'd2, d);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++; $display("FAIL wrap_256: got %h want %h", d, 32'h0);
    end
    n_checks++;
    if (total !== 256) begin
      n_fail++; $display("FAIL wrap_irqs: got %0d want 256", total);
    end
    bus_write(2'd2);
    press_once(irqs);
    bus_read(2'd2, d);
    n_checks++;
    if (d !== 32'h1) begin
      n_fail++; $display("FAIL clear_then_press: got %h want %h", d, 32'h1);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d;
    // Flag is set from the previous press, button released.
    bus_read(2'd1, d);
    n_checks++;
    if (d !== 32'h1) begin
      n_fail++; $display("FAIL pre_clear: got %h want %h", d, 32'h1);
    end
    Btn3 = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++;
    if (btn_irq !== 1'b1) begin
      n_fail++; $display("FAIL coinc_rd_irq: got %b want 1", btn_irq);
    end
    sel = 1'b1; we = 1'b0; addr = 2'd1;
    #1;
    n_checks++;
    if (data_out !== 32'h0) begin
      n_fail++; $display("FAIL coinc_rd_old: got %h want %h", data_out, 32'h0);
    end
    @(negedge clk);
    sel = 1'b0;
    bus_read(2'd1, d);
    n_checks++;
    if (d !== 32'h3) begin
      n_fail++; $display("FAIL coinc_rd_setwins: got %h want %h", d, 32'h3);
    end
    Btn3 = 1'b0;
    repeat (8) @(negedge clk);

    // Counter clear landing on the accept edge: count restarts at 1.
    Btn3 = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++;
    if (btn_irq !== 1'b1) begin
      n_fail++; $display("FAIL coinc_wr_irq: got %b want 1", btn_irq);
    end
    bus_write(2'd2);
    bus_read(2'd2, d);
    n_checks++;
    if (d !== 32'h1) begin
      n_fail++; $display("FAIL coinc_wr_cnt: got %h want %h", d, 32'h1);
    end
    Btn3 = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset_midpend;
    logic [31:0] d;
    Btn3 = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (btn_irq !== 1'b0) begin
      n_fail++; $display("FAIL midrst_irq: got %b want 0", btn_irq);
    end
    for (int unsigned a = 0; a < 3; a++) begin
      sel = 1'b1; we = 1'b0; addr = a[1:0];
      #1;
      n_checks++;
      if (data_out !== 32'h0) begin
        n_fail++; $display("FAIL midrst_read%0d: got %h want %h", a, data_out, 32'h0);
      end
    end
    sel = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    sel = 1'b1; we = 1'b0; addr = 2'd1;
    for (int unsigned k = 1; k <= 6; k++) begin
      @(negedge clk);
      n_checks++;
      if (btn_irq !== (k == 5)) begin
        n_fail++; $display("FAIL midrst_irq_k%0d: got %b want %b", k, btn_irq, (k == 5));
      end
      #1;
      n_checks++;
      if (data_out !== ((k == 6) ? 32'h3 : 32'h0)) begin
        n_fail++; $display("FAIL midrst_rd1_k%0d: got %h want %h", k, data_out,
                           ((k == 6) ? 32'h3 : 32'h0));
      end
    end
    sel = 1'b0;
    @(negedge clk);
    bus_read(2'd2, d);
    n_checks++;
    if (d !== 32'h1) begin
      n_fail++; $display("FAIL midrst_cnt: got %h want %h", d, 32'h1);
    end
    Btn3 = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; sel = 1'b0; we = 1'b0; addr = 2'd0;
    data_in = 32'h0; Sw = 8'h00; Btn3 = 1'b0;
    test_reset;
    test_sw_sync;
    test_bounce;
    test_press;
    test_wrap;
    test_back_to_back;
    test_reset_midpend;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
